// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, position widths and the colour type
// used by the VGA scan controller and its timing sub-block.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical scan counters with raw (unregistered) active and
// active-low sync decode.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_active,
  output logic             o_hs_raw,
  output logic             o_vs_raw
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] C_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_h_wrap = (r_h_cnt == C_H_LAST);
  assign w_v_wrap = (r_v_cnt == C_V_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
      // Lines advance only on the last column, so both wrap together.
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_active = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign o_hs_raw = !((r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END));
  assign o_vs_raw = !((r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END));

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: publishes the scan position to layer modules,
// composites layer-1 over background and registers colour and sync together.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic           clk,
  input  logic           rst,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  input  logic           RqFLag1,
  input  logic [7:0]     r1,
  input  logic [7:0]     g1,
  input  logic [7:0]     b1,
  input  logic [7:0]     bg_r,
  input  logic [7:0]     bg_g,
  input  logic [7:0]     bg_b,
  output logic [7:0]     vga_r,
  output logic [7:0]     vga_g,
  output logic [7:0]     vga_b,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           vga_de,
  output logic           frame_start
);

  localparam logic [CNT_W-1:0] C_V_ACT = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_active;
  logic             w_hs_raw;
  logic             w_vs_raw;
  rgb_t             w_pix;

  rgb_t r_pix;
  logic r_de;
  logic r_hs;
  logic r_vs;
  logic r_fs;

  vga_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_active (w_active),
    .o_hs_raw (w_hs_raw),
    .o_vs_raw (w_vs_raw)
  );

  assign x_pos = w_h_cnt;
  assign y_pos = (w_v_cnt < C_V_ACT) ? w_v_cnt[Y_W-1:0] : '0;

  // Layer answers arrive in the same cycle as the position they belong to.
  always_comb begin
    w_pix = '0;
    if (w_active) begin
      w_pix = RqFLag1 ? {r1, g1, b1} : {bg_r, bg_g, bg_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
      r_de  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_pix <= w_pix;
      r_de  <= w_active;
      r_hs  <= w_hs_raw;
      r_vs  <= w_vs_raw;
      r_fs  <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign vga_r       = r_pix.r;
  assign vga_g       = r_pix.g;
  assign vga_b       = r_pix.b;
  assign vga_de      = r_de;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: a full-size instance for line timing and
// a shrunken-timing instance for frame-level, blanking and mid-frame reset.
module tb_vga_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RqFLag1 = 1'b0;
  logic [7:0] r1 = '0, g1 = '0, b1 = '0;
  logic [7:0] bg_r = '0, bg_g = '0, bg_b = '0;

  logic [9:0] d_x, s_x;
  logic [8:0] d_y, s_y;
  logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;
  logic       d_hs, d_vs, d_de, d_fs, s_hs, s_vs, s_de, s_fs;

  logic        sel = 1'b0;
  logic [27:0] w_out;
  logic [18:0] w_pos;

  always #5 clk = ~clk;

  vga_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .x_pos(d_x), .y_pos(d_y), .RqFLag1(RqFLag1),
    .r1(r1), .g1(g1), .b1(b1), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
    .vga_de(d_de), .frame_start(d_fs)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_s (
    .clk(clk), .rst(rst), .x_pos(s_x), .y_pos(s_y), .RqFLag1(RqFLag1),
    .r1(r1), .g1(g1), .b1(b1), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_de(s_de), .frame_start(s_fs)
  );

  assign w_out = sel ? {s_r, s_g, s_b, s_de, s_hs, s_vs, s_fs}
                     : {d_r, d_g, d_b, d_de, d_hs, d_vs, d_fs};
  assign w_pos = sel ? {s_x, s_y} : {d_x, d_y};

  int errors = 0;
  int checks = 0;

  // model timing and scan position
  int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, ht, vt;
  int hm, vm, e, mode, rlo, rhi;
  logic [27:0] sbq[$];

  // observed timing measurements
  int   hs_first, hs_len, de_len, vs_len, line_cnt, fs_cnt, fs_first, fs_second;
  logic prev_hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (x=%0d y=%0d)", tag, got, exp, hm, vm);
    end
  endtask

  task automatic set_timing(input int a, input int b, input int c, input int d,
                            input int p, input int q, input int r, input int s);
    ha = a; hfp = b; hsw = c; hbp = d; va = p; vfp = q; vsw = r; vbp = s;
    ht = a + b + c + d;
    vt = p + q + r + s;
  endtask

  task automatic reset_meas();
    hs_first = 0; hs_len = 0; de_len = 0; vs_len = 0; line_cnt = 0;
    fs_cnt = 0; fs_first = 0; fs_second = 0; prev_hs = 1'b1;
    hm = 0; vm = 0; e = 0;
    sbq.delete();
  endtask

  // Leaves the bench at a negedge with rst low and the model at (0,0).
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_out", 32'(w_out), 32'h6);
      check("rst_pos", 32'(w_pos), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_meas();
  endtask

  // Called at a negedge: check position, drive the layer, push expectation,
  // then compare after the edge and advance the model.
  task automatic step();
    logic        act, hs, vs, fs, hs_o, vs_o, de_o, fs_o;
    logic [23:0] col;
    logic [27:0] exp;
    int          ey;
    ey = (vm < va) ? vm : 0;
    check("pos", 32'(w_pos), 32'({10'(hm), 9'(ey)}));
    case (mode)
      0: begin
        RqFLag1 = (hm >= rlo) && (hm <= rhi);
        r1 = 8'hFF; g1 = 8'hFF; b1 = 8'hFF;
        bg_r = 8'h10; bg_g = 8'h20; bg_b = 8'h30;
      end
      1: begin
        RqFLag1 = 1'b1;
        r1 = 8'hFF; g1 = 8'hFF; b1 = 8'hFF;
      end
      default: begin
        RqFLag1 = 1'($urandom_range(0, 1));
        r1 = 8'($urandom); g1 = 8'($urandom); b1 = 8'($urandom);
        bg_r = 8'($urandom); bg_g = 8'($urandom); bg_b = 8'($urandom);
      end
    endcase
    act = (hm < ha) && (vm < va);
    col = act ? (RqFLag1 ? {r1, g1, b1} : {bg_r, bg_g, bg_b}) : 24'h0;
    hs  = !((hm >= ha + hfp) && (hm < ha + hfp + hsw));
    vs  = !((vm >= va + vfp) && (vm < va + vfp + vsw));
    fs  = (hm == 0) && (vm == 0);
    sbq.push_back({col, act, hs, vs, fs});

    @(posedge clk); #1;
    e++;
    exp = sbq.pop_front();
    check("out", 32'(w_out), 32'(exp));
    de_o = w_out[3]; hs_o = w_out[2]; vs_o = w_out[1]; fs_o = w_out[0];
    if (mode == 1 && !de_o) check("blank", 32'(w_out[27:4]), 32'h0);
    if (e <= ht) begin
      if (!hs_o) begin
        if (hs_len == 0) hs_first = e;
        hs_len++;
      end
      if (de_o) de_len++;
    end
    if (e <= ht * vt) begin
      if (!vs_o) vs_len++;
      if (!hs_o && prev_hs) line_cnt++;
    end
    if (fs_o) begin
      fs_cnt++;
      if (fs_cnt == 1) fs_first = e;
      else if (fs_cnt == 2) fs_second = e;
    end
    prev_hs = hs_o;

    if (hm == ht - 1) begin
      hm = 0;
      vm = (vm == vt - 1) ? 0 : vm + 1;
    end else begin
      hm++;
    end
    @(negedge clk);
  endtask

  initial begin
    bit reached;

    // Full-size timing: reset, two composited lines, one random line.
    sel = 1'b0;
    set_timing(640, 16, 96, 48, 480, 10, 2, 33);
    rlo = 208; rhi = 239;
    do_reset(5);
    for (int i = 0; i < 3 * 800; i++) begin
      mode = (i < 1600) ? 0 : 2;
      step();
    end
    check("fs_first", 32'(fs_first), 32'd1);
    check("hs_start", 32'(hs_first), 32'd657);
    check("hs_len", 32'(hs_len), 32'd96);
    check("de_len", 32'(de_len), 32'd640);

    // Shrunken timing: composited frame, then blanking-guard frame.
    sel = 1'b1;
    set_timing(64, 4, 8, 4, 20, 2, 2, 3);
    rlo = 8; rhi = 15;
    do_reset(5);
    for (int i = 0; i < 2 * 2160 + 10; i++) begin
      mode = (i < 2160) ? 0 : 1;
      step();
    end
    check("s_hs_start", 32'(hs_first), 32'd69);
    check("s_hs_len", 32'(hs_len), 32'd8);
    check("s_de_len", 32'(de_len), 32'd64);
    check("s_vs_len", 32'(vs_len), 32'd160);
    check("s_lines", 32'(line_cnt), 32'd27);
    check("s_fs_first", 32'(fs_first), 32'd1);
    check("s_fs_period", 32'(fs_second - fs_first), 32'd2160);
    check("s_fs_cnt", 32'(fs_cnt), 32'd3);

    // Mid-frame asynchronous reset at line 12, column 40.
    mode = 2;
    reached = 1'b0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      if (hm == 40 && vm == 12) reached = 1'b1;
      else step();
    end
    check("reach_mid", 32'(reached), 32'd1);
    check("pre_rst_de", 32'(w_out[3]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out", 32'(w_out), 32'h6);
    check("async_pos", 32'(w_pos), 32'h0);
    @(posedge clk); #1;
    check("hold_out", 32'(w_out), 32'h6);
    @(negedge clk);
    rst = 1'b0;
    reset_meas();
    mode = 0;
    for (int i = 0; i < 2160 + 5; i++) step();
    check("r_fs_first", 32'(fs_first), 32'd1);
    check("r_fs_cnt", 32'(fs_cnt), 32'd2);
    check("r_hs_start", 32'(hs_first), 32'd69);
    check("r_hs_len", 32'(hs_len), 32'd8);
    check("r_vs_len", 32'(vs_len), 32'd160);
    check("r_lines", 32'(line_cnt), 32'd27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
